// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Purpose:
//   Multi-cycle sequencer that owns the program counter and runs the
//   instruction-fetch handshake. Each instruction goes through
//   FETCH -> ISSUE -> ADVANCE. In ADVANCE the PC is advanced by the output
//   of an external operand mux. This block drives that mux's select line:
//   1 selects the constant 2 (sequential step), and 0 selects the branch
//   offset.
//
// Optional feature macro:
//   PC_ALIGN_CHECK_EN - when defined, ADVANCE refuses to load an odd PC.
//                       In that case it sets AlignFault and halts instead.
//                       When undefined, align_fault_o is tied to 0.
//
// Parameters:
//   WIDTH    - PC / address / mux datapath width
//   RESET_PC - PC value loaded on reset
//   MAX_WAIT - number of fetch-ack wait cycles before timeout (1..255)
//
// Ports:
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   start_i          leave IDLE and begin fetching
//   halt_i           stop after the current PC update (sampled in IDLE/ADVANCE)
//   fetch_req_o      fetch request to instruction memory
//   fetch_addr_o     fetch address (= pc_o)
//   fetch_ack_i      instruction memory returned data
//   instr_valid_o    fetched instruction available to decode
//   instr_ready_i    decode accepts instruction; qualifies branch_taken_i
//   branch_taken_i   1 = next PC uses the offset, 0 = sequential
//   operand_sel_o    mux select: 1 = constant 2, 0 = offset
//   mux_out_i        mux output (2 or branch offset)
//   pc_o             current program counter
//   busy_o           state is neither IDLE nor HALTED
//   fetch_timeout_o  sticky fetch-timeout flag
//   align_fault_o    sticky misaligned-PC flag (0 unless PC_ALIGN_CHECK_EN)
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
  parameter int unsigned       WIDTH    = 17,
  parameter logic [WIDTH-1:0]  RESET_PC = '0,
  parameter int unsigned       MAX_WAIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_i,
  output logic             fetch_req_o,
  output logic [WIDTH-1:0] fetch_addr_o,
  input  logic             fetch_ack_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  input  logic             branch_taken_i,
  output logic             operand_sel_o,
  input  logic [WIDTH-1:0] mux_out_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             busy_o,
  output logic             fetch_timeout_o,
  output logic             align_fault_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  // Cycle count at which an un-acked fetch gives up. The counter holds the
  // number of wait cycles already spent, so the cycle that would bring it to
  // MAX_WAIT is the last chance for an ack.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             op_sel_q, op_sel_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] pc_sum;

  // Wrap-around modulo 2^WIDTH is intentional.
  assign pc_sum = pc_q + mux_out_i;

`ifdef PC_ALIGN_CHECK_EN
  logic align_q, align_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    op_sel_d   = op_sel_q;
    timeout_d  = timeout_q;
`ifdef PC_ALIGN_CHECK_EN
    align_d    = align_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end else if (halt_i) begin
          state_d = S_HALTED;
        end
      end

      S_FETCH: begin
        if (fetch_ack_i) begin
          // An ack wins even on the cycle that would otherwise time out.
          state_d    = S_ISSUE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = S_HALTED;
          wait_cnt_d = wait_cnt_q + 8'd1;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_ISSUE: begin
        // branch_taken_i has meaning only when decode accepts the instruction.
        if (instr_ready_i) begin
          op_sel_d = ~branch_taken_i;
          state_d  = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        op_sel_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        if (pc_sum[0]) begin
          // A misaligned target overrides halt and leaves the PC untouched.
          align_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          pc_d    = pc_sum;
          state_d = halt_i ? S_HALTED : S_FETCH;
        end
`else
        pc_d    = pc_sum;
        state_d = halt_i ? S_HALTED : S_FETCH;
`endif
      end

      S_HALTED: begin
        // Terminal state. Only reset leaves it.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      op_sel_q   <= 1'b1;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      op_sel_q   <= op_sel_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      align_q <= 1'b0;
    end else begin
      align_q <= align_d;
    end
  end
  assign align_fault_o = align_q;
`else
  assign align_fault_o = 1'b0;
`endif

  // Every output is a register or a pure decode of the state register.
  assign fetch_req_o     = (state_q == S_FETCH);
  assign fetch_addr_o    = pc_q;
  assign instr_valid_o   = (state_q == S_ISSUE);
  assign operand_sel_o   = op_sel_q;
  assign pc_o            = pc_q;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign fetch_timeout_o = timeout_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;
  localparam int W = 17;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i, halt_i, fetch_ack_i, instr_ready_i, branch_taken_i;
  logic         fetch_req_o, instr_valid_o, operand_sel_o, busy_o;
  logic         fetch_timeout_o, align_fault_o;
  logic [W-1:0] fetch_addr_o, mux_out_i, pc_o;
  logic [W-1:0] offset_drv;

  always #5 clk_i = ~clk_i;

  // The bench plays the role of the combinational operand mux.
  assign mux_out_i = operand_sel_o ? W'(2) : offset_drv;

  pc_fetch_sequencer #(.WIDTH(W), .RESET_PC('0), .MAX_WAIT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .halt_i(halt_i),
    .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o),
    .fetch_ack_i(fetch_ack_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .branch_taken_i(branch_taken_i),
    .operand_sel_o(operand_sel_o), .mux_out_i(mux_out_i), .pc_o(pc_o),
    .busy_o(busy_o), .fetch_timeout_o(fetch_timeout_o),
    .align_fault_o(align_fault_o)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] model_pc;
  logic [W-1:0] exp_q[$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; start_i = 0; halt_i = 0; fetch_ack_i = 0;
    instr_ready_i = 0; branch_taken_i = 0; offset_drv = '0;
    model_pc = '0;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Leave IDLE. On return the DUT is in its first FETCH cycle.
  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Run one instruction. The DUT must be in its first FETCH cycle on entry.
  task automatic run_instr(input logic br, input logic [W-1:0] off,
                           input int ack_dly, input int rdy_dly, input logic hlt);
    logic [W-1:0] sum;
    logic [W-1:0] exp_pc;
    n_cmp++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== model_pc) begin
      n_bad++;
      $display("FAIL fetch_req: got req=%b addr=%h required req=1 addr=%h",
               fetch_req_o, fetch_addr_o, model_pc);
    end
    fetch_ack_i = 1'b0;
    for (int i = 0; i < ack_dly; i++) step();
    fetch_ack_i = 1'b1;
    step();
    fetch_ack_i = 1'b0;
    halt_i = hlt;
    n_cmp++;
    if (instr_valid_o !== 1'b1 || fetch_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL issue_entry: got valid=%b req=%b required valid=1 req=0",
               instr_valid_o, fetch_req_o);
    end
    // Opposite branch value while not ready must be ignored.
    branch_taken_i = ~br;
    offset_drv = off;
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      n_cmp++;
      if (instr_valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL valid_hold: got %b required 1 (stall %0d)", instr_valid_o, i);
      end
    end
    instr_ready_i  = 1'b1;
    branch_taken_i = br;
    sum = model_pc + (br ? off : W'(2));
    exp_pc = sum;
`ifdef PC_ALIGN_CHECK_EN
    if (sum[0]) exp_pc = model_pc;
`endif
    exp_q.push_back(exp_pc);
    step();
    instr_ready_i  = 1'b0;
    branch_taken_i = 1'b0;
    // ADVANCE cycle
    n_cmp++;
    if (operand_sel_o !== ~br || instr_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL advance: got sel=%b valid=%b busy=%b required sel=%b valid=0 busy=1",
               operand_sel_o, instr_valid_o, busy_o, ~br);
    end
    step();
    halt_i = 1'b0;
    exp_pc = exp_q.pop_front();
    n_cmp++;
    if (pc_o !== exp_pc || operand_sel_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pc_update: got pc=%h sel=%b required pc=%h sel=1",
               pc_o, operand_sel_o, exp_pc);
    end
    $display("instr: pc %h -> %h br=%b off=%h ackdly=%0d rdydly=%0d halt=%b",
             model_pc, exp_pc, br, off, ack_dly, rdy_dly, hlt);
    model_pc = exp_pc;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (pc_o !== '0 || operand_sel_o !== 1'b1 || fetch_req_o !== 1'b0 ||
        instr_valid_o !== 1'b0 || busy_o !== 1'b0 || fetch_timeout_o !== 1'b0 ||
        align_fault_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got pc=%h sel=%b req=%b val=%b busy=%b to=%b af=%b required 0,1,0,0,0,0,0",
               pc_o, operand_sel_o, fetch_req_o, instr_valid_o, busy_o,
               fetch_timeout_o, align_fault_o);
    end
    $display("reset: pc=%h busy=%b", pc_o, busy_o);
  endtask

  task automatic test_sequential();
    do_start();
    run_instr(1'b0, '0, 0, 0, 1'b0);
    run_instr(1'b0, '0, 0, 0, 1'b0);
  endtask

  task automatic test_branch();
    run_instr(1'b1, W'(17'h00010), 0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_instr(1'b1, W'(17'h1FFEA), 0, 0, 1'b0);
    run_instr(1'b0, '0, 0, 0, 1'b0);
    n_cmp++;
    if (align_fault_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_flags: got af=%b busy=%b required af=0 busy=1",
               align_fault_o, busy_o);
    end
  endtask

  task automatic test_halt_backpressure();
    logic [W-1:0] frozen;
    run_instr(1'b0, '0, 3, 4, 1'b1);
    frozen = pc_o;
    start_i = 1'b1;
    repeat (3) step();
    start_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || fetch_req_o !== 1'b0 || instr_valid_o !== 1'b0 ||
        pc_o !== frozen) begin
      n_bad++;
      $display("FAIL halted: got busy=%b req=%b val=%b pc=%h required 0,0,0 pc=%h",
               busy_o, fetch_req_o, instr_valid_o, pc_o, frozen);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    do_start();
    run_instr(1'b0, '0, 0, 0, 1'b0);
    step();
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (pc_o !== '0 || busy_o !== 1'b0 || fetch_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got pc=%h busy=%b req=%b required pc=0 busy=0 req=0",
               pc_o, busy_o, fetch_req_o);
    end
    $display("async reset mid-fetch: pc=%h", pc_o);
    model_pc = '0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_idle_halt();
    do_reset();
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || fetch_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_halt: got busy=%b req=%b required 0,0", busy_o, fetch_req_o);
    end
    // Start and halt together: start wins.
    do_reset();
    start_i = 1'b1; halt_i = 1'b1;
    step();
    start_i = 1'b0; halt_i = 1'b0;
    n_cmp++;
    if (fetch_req_o !== 1'b1 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL start_wins: got req=%b busy=%b required 1,1", fetch_req_o, busy_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    repeat (14) step();
    n_cmp++;
    if (fetch_req_o !== 1'b1 || fetch_timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_timeout: got req=%b to=%b required 1,0", fetch_req_o, fetch_timeout_o);
    end
    step();
    n_cmp++;
    if (fetch_timeout_o !== 1'b1 || busy_o !== 1'b0 || fetch_req_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout: got to=%b busy=%b req=%b required 1,0,0",
               fetch_timeout_o, busy_o, fetch_req_o);
    end
    $display("timeout: to=%b busy=%b", fetch_timeout_o, busy_o);
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    do_start();
    run_instr(1'b0, '0, 14, 0, 1'b0);
    n_cmp++;
    if (fetch_timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ack_at_limit: got to=%b busy=%b required 0,1", fetch_timeout_o, busy_o);
    end
  endtask

  task automatic test_align();
    do_reset();
    do_start();
    run_instr(1'b1, W'(3), 0, 0, 1'b0);
    n_cmp++;
`ifdef PC_ALIGN_CHECK_EN
    if (align_fault_o !== 1'b1 || busy_o !== 1'b0 || pc_o !== '0) begin
      n_bad++;
      $display("FAIL align: got af=%b busy=%b pc=%h required af=1 busy=0 pc=0",
               align_fault_o, busy_o, pc_o);
    end
`else
    if (align_fault_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== W'(3)) begin
      n_bad++;
      $display("FAIL align: got af=%b busy=%b pc=%h required af=0 busy=1 pc=3",
               align_fault_o, busy_o, pc_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_halt_backpressure();
    test_reset_mid_fetch();
    test_idle_halt();
    test_timeout();
    test_ack_at_limit();
    test_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
